// File: rtl/fifo_rd_pkg.sv
// Package for the FIFO read-side stream controller.
// Holds the output buffer depth, the occupancy type and the occupancy
// update helper shared by the top level and the buffer.
package fifo_rd_pkg;

    localparam int BUF_DEPTH = 2;

    typedef logic [1:0] occ_t;

    // Next occupancy after an optional push and an optional pop.
    // The read issue rule keeps the result within 0..BUF_DEPTH.
    function automatic occ_t occ_next(input occ_t occ, input logic push, input logic pop);
        return occ_t'(occ + occ_t'(push) - occ_t'(pop));
    endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry in-order register buffer.
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - synchronous active-high reset
//   push_i  - write data_i into the tail this cycle
//   pop_i   - drop the head this cycle (only while occ_o != 0)
//   data_i  - word to push
//   occ_o   - number of valid entries (0..2), registered
//   head_o  - head entry, zero when empty, registered
module stream_buf2
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output occ_t             occ_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] e0_q, e0_d;
    logic [WIDTH-1:0] e1_q, e1_d;
    occ_t             occ_q, occ_d;

    // Next-state for the two entries; entry 0 is always the head and is
    // zeroed whenever the buffer drains so the head reads 0 when empty.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_next(occ_q, push_i, pop_i);
        case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    e0_d = data_i;
                end else begin
                    e1_d = data_i;
                end
            end
            2'b01: begin
                if (occ_q == occ_t'(BUF_DEPTH)) begin
                    e0_d = e1_q;
                end else begin
                    e0_d = {WIDTH{1'b0}};
                end
                e1_d = {WIDTH{1'b0}};
            end
            2'b11: begin
                // Head advances and the new word lands behind it.
                if (occ_q == occ_t'(BUF_DEPTH)) begin
                    e0_d = e1_q;
                    e1_d = data_i;
                end else begin
                    e0_d = data_i;
                    e1_d = {WIDTH{1'b0}};
                end
            end
            default: begin
                e0_d = e0_q;
                e1_d = e1_q;
            end
        endcase
    end

    // Buffer state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            e0_q  <= {WIDTH{1'b0}};
            e1_q  <= {WIDTH{1'b0}};
            occ_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = e0_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a fifo through read_en/data_out/empty and presents the words as a
// valid/ready stream at one word per clock, hiding the fifo's one-cycle
// read latency behind a two-entry buffer. Counts delivered words.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   fifo_empty      - fifo empty flag
//   fifo_data_out   - fifo read data, valid the cycle after a read
//   fifo_read_en    - fifo read strobe (combinational)
//   out_valid       - stream valid (buffer non-empty)
//   out_ready       - stream ready from the consumer
//   out_data        - stream data (buffer head, 0 when empty)
//   word_count      - words accepted downstream, wrapping
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data_out,
    output logic             fifo_read_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] word_count
);

    occ_t             occ_s;
    logic             pop_s;
    logic [2:0]       budget_s;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;

    assign pop_s = out_valid & out_ready;

    // Slots committed after this cycle: held words plus the word in flight,
    // less the one leaving now. A new read is only issued if it will fit.
    assign budget_s     = {1'b0, occ_s} + {2'b00, inflight_q} - {2'b00, pop_s};
    assign fifo_read_en = !rst & !fifo_empty & (budget_s < 3'd2);

    // Next-state for the in-flight flag and the delivered-word counter.
    always_comb begin
        inflight_d = fifo_read_en;
        if (pop_s) begin
            word_count_d = word_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            word_count_d = word_count_q;
        end
    end

    // In-flight flag and counter registers; clearing inflight on reset
    // discards any word the fifo returns just after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q   <= 1'b0;
            word_count_q <= {CNT_W{1'b0}};
        end else begin
            inflight_q   <= inflight_d;
            word_count_q <= word_count_d;
        end
    end

    stream_buf2 #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk_i  (clk),
        .rst_i  (rst),
        .push_i (inflight_q),
        .pop_i  (pop_s),
        .data_i (fifo_data_out),
        .occ_o  (occ_s),
        .head_o (out_data)
    );

    assign out_valid  = (occ_s != 2'd0);
    assign word_count = word_count_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural depth-4 fifo.
module tb_fifo_stream_reader;

    logic       clk;
    logic       rst;
    logic       fifo_empty;
    logic [7:0] fifo_data_out;
    logic       fifo_read_en;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] word_count;

    // fifo model state
    logic [7:0] mem [4];
    logic [1:0] rp, wp;
    logic [2:0] cnt;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_s, wr_s;
    int         nreads;
    int         bad_reads;

    int total;
    int bad;
    int base;

    fifo_stream_reader #(.WIDTH(8), .CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_read_en  (fifo_read_en),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .word_count    (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = (cnt == 3'd0);
    assign rd_s = fifo_read_en && (cnt != 3'd0);
    assign wr_s = wr_en && ((cnt != 3'd4) || rd_s);

    initial begin
        nreads        = 0;
        bad_reads     = 0;
        fifo_data_out = 8'h00;
    end

    // fifo model: one-cycle read latency, data register not cleared by reset
    always @(posedge clk) begin
        if (fifo_read_en && (cnt == 3'd0)) bad_reads <= bad_reads + 1;
        if (rst) begin
            rp  <= 2'd0;
            wp  <= 2'd0;
            cnt <= 3'd0;
        end else begin
            if (rd_s) begin
                fifo_data_out <= mem[rp];
                rp            <= rp + 2'd1;
                nreads        <= nreads + 1;
            end
            if (wr_s) begin
                mem[wp] <= wr_data;
                wp      <= wp + 2'd1;
            end
            cnt <= cnt + {2'b00, wr_s} - {2'b00, rd_s};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        tick();
        chk("rst_read_en", 32'(fifo_read_en), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        out_ready = 1'b0;
        tick();
        do_reset();

        // Single word
        base      = nreads;
        out_ready = 1'b1;
        wr_en     = 1'b1;
        wr_data   = 8'hA5;
        tick();
        wr_en = 1'b0;
        #1;
        chk("single_read_en_hi", 32'(fifo_read_en), 32'd1);
        tick();
        chk("single_read_en_lo", 32'(fifo_read_en), 32'd0);
        chk("single_valid_early", 32'(out_valid), 32'd0);
        tick();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'hA5);
        tick();
        chk("single_valid_after", 32'(out_valid), 32'd0);
        chk("single_data_after", 32'(out_data), 32'd0);
        chk("single_count", 32'(word_count), 32'd1);
        chk("single_reads", 32'(nreads - base), 32'd1);

        // Streaming four words with out_ready high
        do_reset();
        out_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            wr_en   = (s < 4);
            wr_data = 8'(8'h11 * (s + 1));
            if (s >= 3 && s <= 6) begin
                chk("stream_valid", 32'(out_valid), 32'd1);
                chk("stream_data", 32'(out_data), 32'(8'(8'h11 * (s - 2))));
            end
            tick();
        end
        chk("stream_valid_end", 32'(out_valid), 32'd0);
        chk("stream_count", 32'(word_count), 32'd4);

        // Back-pressure: ten cycles with out_ready low once the buffer fills
        do_reset();
        out_ready = 1'b0;
        base      = nreads;
        for (int s = 0; s < 14; s++) begin
            wr_en   = (s < 4);
            wr_data = 8'(8'h11 * (s + 1));
            if (s >= 4) begin
                chk("bp_read_en", 32'(fifo_read_en), 32'd0);
                chk("bp_hold_data", 32'(out_data), 32'h11);
            end
            tick();
        end
        chk("bp_reads", 32'(nreads - base), 32'd2);
        chk("bp_fifo_not_empty", 32'(fifo_empty), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_read_en", 32'(fifo_read_en), 32'd1);
        chk("bp_rel_data0", 32'(out_data), 32'h11);
        tick();
        chk("bp_rel_data1", 32'(out_data), 32'h22);
        tick();
        chk("bp_rel_data2", 32'(out_data), 32'h33);
        tick();
        chk("bp_rel_valid3", 32'(out_valid), 32'd1);
        chk("bp_rel_data3", 32'(out_data), 32'h44);
        tick();
        chk("bp_valid_end", 32'(out_valid), 32'd0);
        chk("bp_count", 32'(word_count), 32'd4);

        // Reset with the buffer full
        out_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h50 + s);
            tick();
        end
        wr_en = 1'b0;
        chk("rm_full_data", 32'(out_data), 32'h50);
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("rm_valid", 32'(out_valid), 32'd0);
        chk("rm_count", 32'(word_count), 32'd0);
        chk("rm_read_en", 32'(fifo_read_en), 32'd0);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("rm_quiet_valid", 32'(out_valid), 32'd0);
        end

        // Reset with a read in flight: the returning word must not appear
        out_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h61 + s);
            tick();
        end
        wr_en = 1'b0;
        #1;
        chk("stale_read_en_pre", 32'(fifo_read_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("stale_read_en_rst", 32'(fifo_read_en), 32'd0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            chk("stale_valid", 32'(out_valid), 32'd0);
            tick();
        end
        chk("stale_count", 32'(word_count), 32'd0);

        // Empty guard
        do_reset();
        out_ready = 1'b1;
        for (int s = 0; s < 20; s++) begin
            tick();
            chk("empty_read_en", 32'(fifo_read_en), 32'd0);
            chk("empty_valid", 32'(out_valid), 32'd0);
        end

        // Counter wrap with a 4-bit counter and 17 words
        do_reset();
        out_ready = 1'b1;
        for (int s = 0; s < 22; s++) begin
            wr_en   = (s < 17);
            wr_data = 8'(8'h40 + s);
            if (s >= 3 && s < 20) begin
                chk("wrap_data", 32'(out_data), 32'(8'(8'h40 + s - 3)));
            end
            if (s == 19) begin
                chk("wrap_count_zero", 32'(word_count), 32'd0);
            end
            tick();
        end
        chk("wrap_count", 32'(word_count), 32'd1);
        chk("wrap_valid_end", 32'(out_valid), 32'd0);

        chk("never_read_empty", 32'(bad_reads), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side controller that drains a `fifo` instance through its `read_en`/`data_out`/`empty` port and presents the words as a valid/ready stream. It hides the FIFO's one-cycle read latency behind a two-entry output buffer, so the stream runs at one word per clock with back-pressure. It sits between a `fifo` and any downstream stream consumer, and counts the words it delivers.

## Interface
- `WIDTH`, default 8: data word width; must match the `fifo` instance.
- `CNT_W`, default 16: width of the delivered-word counter.

Ports:
- `clk` input 1: clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `fifo_empty` input 1: `empty` flag from the `fifo`.
- `fifo_data_out` input WIDTH: `data_out` from the `fifo`; valid the cycle after an accepted `read_en`.
- `fifo_read_en` output 1: drives the `fifo` `read_en`.
- `out_valid` output 1: `out_data` holds a word.
- `out_ready` input 1: consumer accepts the word this cycle.
- `out_data` output WIDTH: head word of the output buffer.
- `word_count` output CNT_W: number of words accepted downstream, modulo 2^CNT_W.

## Operation
- Reset values: `fifo_read_en`=0, `out_valid`=0, `out_data`=0, `word_count`=0. Buffer occupancy `occ`=0 and `inflight`=0.
- `pop` = `out_valid & out_ready`.
- Read issue (combinational): `fifo_read_en` = `!fifo_empty & (occ + inflight - pop < 2)`.
  - `fifo_read_en` is never asserted while `fifo_empty`=1.
  - It is forced to 0 while `rst`=1.
- `inflight` is registered: `inflight` <= `fifo_read_en`.
- Capture: when `inflight`=1, `fifo_data_out` is written into the buffer tail that cycle.
- Occupancy update: `occ` <= `occ` + `inflight` - `pop`. The range 0..2 is guaranteed by the issue rule, so there is no overflow path.
- Output: `out_valid` = (`occ` != 0). `out_data` = head entry; it is 0 when `occ`=0.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- Hold rule: while `out_valid` & !`out_ready`, `out_data` is held stable.
- Counter: `word_count` increments by 1 on every `pop`. It wraps from 2^CNT_W-1 to 0 with no flag.
- Simultaneous events:
  - capture and pop in the same cycle: the head advances and the new word enters the tail, so `occ` is unchanged.
  - pop with `occ`=2: entry 1 becomes the head in the next cycle.
- Reset mid-operation: buffer, `inflight` and counter are cleared. A word returned in the cycle after reset is discarded. The `fifo` is reset on the same `rst` domain.

## Timing
- Latency from `fifo_empty` falling (sampled in cycle N, reader idle, `out_ready`=1):
  - `fifo_read_en`=1 in cycle N;
  - data captured at the end of N+1;
  - `out_valid`=1 in N+2.
- Throughput: with `out_ready` held high and the `fifo` non-empty, one word per cycle after the first.
- With `out_ready`=0: at most two reads are issued; `fifo_read_en` then stays 0 until a pop.
- There are no combinational paths from `out_ready` to `out_valid`/`out_data`. The only such path is `out_ready`→`fifo_read_en`, through `pop`.

## Structure
- Package `fifo_rd_pkg` holds:
  - localparam `BUF_DEPTH`=2;
  - typedef `occ_t` (logic [1:0]).
- Sub-module `stream_buf2`: two-entry, in-order register buffer with push/pop/occupancy. The top level holds the issue logic, `inflight` and `word_count`.

## Test plan
All scenarios use `WIDTH`=8, against a real `fifo` DEPTH=4.
- Single word: write 0xA5 into the `fifo`, `out_ready`=1 → `fifo_read_en` pulses once, `out_valid`=1 two cycles later with 0xA5, `word_count`=1.
- Streaming: write 0x11, 0x22, 0x33, 0x44, `out_ready`=1 → four consecutive `out_valid` cycles in order, `word_count`=4, then `out_valid`=0.
- Back-pressure: same 4 words with `out_ready`=0 for 10 cycles → exactly 2 reads issued, `out_data`=0x11 stable, `fifo` not empty; release → 0x11..0x44 in order, no gaps after the first.
- Empty guard: `fifo` empty for 20 cycles → `fifo_read_en` never asserted, `out_valid`=0.
- Reset mid-stream: assert `rst` while `occ`=2 → next cycle `out_valid`=0, `word_count`=0, `fifo_read_en`=0; the stale returning word is never presented.
- Counter wrap: `CNT_W`=4, 17 words → `word_count` = 1.
